// File: rtl/dr32e_id_ctrl.sv
// rtl/dr32e_id_ctrl.sv - ID/EX instruction-sequencing controller for dr32e
//
// Decides when each decoded instruction retires. Stalls ID for multicycle
// mult/div and load/store. Redirects fetch for jumps, traps and mret, and
// parks the core in WFI sleep.
//
// Optional feature macro: DR32E_WFI_EN
//   defined   : WFI retires, enters SLEEP and wakes on a pending interrupt
//   undefined : WFI is a single-cycle NOP, no SLEEP state, core_sleep_o = 0
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   instr_valid_i          decoded instruction present in ID
//   illegal/ecall/ebrk/mret/wfi_insn_i  decoder classification
//   jump_set_i, branch_in_dec_i, branch_taken_i  control-flow info
//   multdiv_en_i, multdiv_done_i        mult/div request / result valid
//   data_req_i, data_we_i               load/store request, 1 = store
//   lsu_resp_valid_i, lsu_err_i         LSU response / bus error
//   irq_pending_i          enabled interrupt pending
//   instr_req_o            fetch enable
//   pc_set_o, pc_mux_o     fetch redirect and source (0 boot, 1 jump, 2 mtvec, 3 mepc)
//   flush_id_o, stall_o    kill / hold the ID stage
//   instr_retire_o         retire pulse
//   csr_save_cause_o, csr_restore_mret_o  CSR side effects in the redirect cycle
//   exc_cause_o            registered trap cause (bit5 = interrupt)
//   core_sleep_o           registered WFI sleep indication
module dr32e_id_ctrl #(
  parameter int unsigned MTVEC_IDX = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       instr_valid_i,
  input  logic       illegal_insn_i,
  input  logic       ecall_insn_i,
  input  logic       ebrk_insn_i,
  input  logic       mret_insn_i,
  input  logic       wfi_insn_i,
  input  logic       jump_set_i,
  input  logic       branch_in_dec_i,
  input  logic       branch_taken_i,
  input  logic       multdiv_en_i,
  input  logic       multdiv_done_i,
  input  logic       data_req_i,
  input  logic       data_we_i,
  input  logic       lsu_resp_valid_i,
  input  logic       lsu_err_i,
  input  logic       irq_pending_i,
  output logic       instr_req_o,
  output logic       pc_set_o,
  output logic [1:0] pc_mux_o,
  output logic       flush_id_o,
  output logic       stall_o,
  output logic       instr_retire_o,
  output logic       csr_save_cause_o,
  output logic       csr_restore_mret_o,
  output logic [5:0] exc_cause_o,
  output logic       core_sleep_o
);

  typedef enum logic [2:0] {
    S_RESET,
    S_BOOT,
    S_DECODE,
    S_WAIT_MD,
    S_WAIT_LSU,
    S_FLUSH
`ifdef DR32E_WFI_EN
    , S_SLEEP
`endif
  } state_t;

  localparam logic [5:0] CAUSE_IRQ     = 6'h2B;
  localparam logic [5:0] CAUSE_ILLEGAL = 6'h02;
  localparam logic [5:0] CAUSE_ECALL   = 6'h0B;
  localparam logic [5:0] CAUSE_EBREAK  = 6'h03;
  localparam logic [5:0] CAUSE_ST_ERR  = 6'h07;
  localparam logic [5:0] CAUSE_LD_ERR  = 6'h05;

  state_t     state_q, state_d;
  logic       mret_q, mret_d;
  logic [5:0] cause_q, cause_d;
  // Store/load direction is captured at issue so the error cause does not
  // depend on what the decoder presents while the LSU is busy.
  logic       we_q, we_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_RESET;
      mret_q  <= 1'b0;
      cause_q <= 6'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mret_q  <= mret_d;
      cause_q <= cause_d;
      we_q    <= we_d;
    end
  end

`ifdef DR32E_WFI_EN
  logic sleep_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sleep_q <= 1'b0;
    end else begin
      sleep_q <= (state_d == S_SLEEP);
    end
  end
  assign core_sleep_o = sleep_q;
`else
  assign core_sleep_o = 1'b0;
`endif

  assign exc_cause_o = cause_q;

  always_comb begin
    state_d            = state_q;
    mret_d             = mret_q;
    cause_d            = cause_q;
    we_d               = we_q;
    instr_req_o        = 1'b0;
    pc_set_o           = 1'b0;
    pc_mux_o           = 2'd0;
    flush_id_o         = 1'b0;
    stall_o            = 1'b0;
    instr_retire_o     = 1'b0;
    csr_save_cause_o   = 1'b0;
    csr_restore_mret_o = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_BOOT;
      end

      S_BOOT: begin
        instr_req_o = 1'b1;
        pc_set_o    = 1'b1;
        pc_mux_o    = 2'd0;
        state_d     = S_DECODE;
      end

      S_DECODE: begin
        instr_req_o = 1'b1;
        if (instr_valid_i) begin
          if (irq_pending_i) begin
            cause_d = CAUSE_IRQ;
            state_d = S_FLUSH;
          end else if (illegal_insn_i) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_FLUSH;
          end else if (ecall_insn_i) begin
            cause_d = CAUSE_ECALL;
            state_d = S_FLUSH;
          end else if (ebrk_insn_i) begin
            cause_d = CAUSE_EBREAK;
            state_d = S_FLUSH;
          end else if (mret_insn_i) begin
            instr_retire_o = 1'b1;
            mret_d         = 1'b1;
            state_d        = S_FLUSH;
          end else if (wfi_insn_i) begin
            instr_retire_o = 1'b1;
`ifdef DR32E_WFI_EN
            state_d        = S_SLEEP;
`endif
          end else if (multdiv_en_i) begin
            stall_o = 1'b1;
            state_d = S_WAIT_MD;
          end else if (data_req_i) begin
            stall_o = 1'b1;
            we_d    = data_we_i;
            state_d = S_WAIT_LSU;
          end else if (jump_set_i || (branch_in_dec_i && branch_taken_i)) begin
            instr_retire_o = 1'b1;
            pc_set_o       = 1'b1;
            pc_mux_o       = 2'd1;
            flush_id_o     = 1'b1;
          end else begin
            instr_retire_o = 1'b1;
          end
        end
      end

      S_WAIT_MD: begin
        instr_req_o = 1'b1;
        if (multdiv_done_i) begin
          instr_retire_o = 1'b1;
          state_d        = S_DECODE;
        end else begin
          stall_o = 1'b1;
        end
      end

      S_WAIT_LSU: begin
        instr_req_o = 1'b1;
        if (lsu_resp_valid_i) begin
          if (lsu_err_i) begin
            cause_d = we_q ? CAUSE_ST_ERR : CAUSE_LD_ERR;
            state_d = S_FLUSH;
          end else begin
            instr_retire_o = 1'b1;
            state_d        = S_DECODE;
          end
        end else begin
          stall_o = 1'b1;
        end
      end

      S_FLUSH: begin
        instr_req_o = 1'b1;
        pc_set_o    = 1'b1;
        flush_id_o  = 1'b1;
        if (mret_q) begin
          pc_mux_o           = 2'd3;
          csr_restore_mret_o = 1'b1;
        end else begin
          pc_mux_o         = MTVEC_IDX[1:0];
          csr_save_cause_o = 1'b1;
        end
        mret_d  = 1'b0;
        state_d = S_DECODE;
      end

`ifdef DR32E_WFI_EN
      S_SLEEP: begin
        if (irq_pending_i) begin
          cause_d = CAUSE_IRQ;
          state_d = S_FLUSH;
        end
      end
`endif

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

endmodule
